sample_writer: RTL
==================

# sample_writer

Recording-side counterpart to the sample collector: accepts 8-bit samples arriving at the sampling strobe, buffers them in a small FIFO, and writes them sequentially into external sample memory. The collector later reads from that memory. Sits between the ADC/codec deserializer and the SRAM write port, under control of the top-level record FSM (start/stop pulses).

## Interface
- ADDR_W, 20, sample-memory address width; capacity 2**ADDR_W samples
- FIFO_DEPTH, 16, buffer entries; power of two, ≥2

- i_clk  in  1  single clock; all logic on posedge
- i_rst  in  1  reset, synchronous, active-high
- i_start  in  1  one-cycle pulse: begin recording at address 0
- i_stop  in  1  one-cycle pulse: end recording, drain buffer
- i_valid  in  1  sample strobe; i_data valid this cycle
- i_data  in  8  sample
- o_addr  out  ADDR_W  memory write address
- o_data  out  8  memory write data
- o_we  out  1  write request; held until accepted
- i_ready  in  1  memory accepts write when o_we && i_ready
- o_busy  out  1  high in RUN or DRAIN
- o_done  out  1  one-cycle pulse on recording completion
- o_count  out  ADDR_W+1  samples written in current/last recording
- o_overflow  out  1  sticky: a sample was dropped (only with SAMPLE_WRITER_OVF_EN)

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: i_valid ignored. i_start → RUN; same edge clears addr, o_count, FIFO, o_overflow. i_stop ignored.
- RUN: i_valid pushes i_data into FIFO. If FIFO is full and no pop occurs that cycle, the sample is dropped and o_overflow is set. Push and pop on a full FIFO in the same cycle both proceed; no drop. i_start ignored. i_stop → DRAIN; a sample with i_valid on the i_stop cycle is still pushed.
- DRAIN: i_valid ignored. Writes continue. FIFO empty with no write pending → DONE.
- Write port (RUN/DRAIN): o_we = FIFO not empty; o_data = FIFO head; o_addr = addr. On o_we && i_ready: pop, addr++, o_count++.
- Memory full: when o_count reaches 2**ADDR_W, go from RUN or DRAIN → DONE. Any remaining FIFO contents are discarded. In RUN, samples arriving on the transition cycle are dropped and flagged as overflow. addr never wraps to overwrite sample 0.
- DONE: o_done = 1 for exactly one cycle → IDLE. o_count and o_overflow hold until the next i_start.
- Reset: synchronous reset at any time, including mid-write, returns to IDLE with an empty FIFO. No o_done pulse.

## Timing
- Reset values: o_addr=0, o_data=0, o_we=0, o_busy=0, o_done=0, o_count=0, o_overflow=0.
- o_busy is registered: high the cycle after i_start is sampled.
- Latency: i_valid at cycle t → o_we high at t+1, with that sample on o_data, when the FIFO was empty.
- o_addr/o_data stable while o_we && !i_ready.
- Throughput: one write per cycle while i_ready is held high.
- o_done asserts the cycle after the last accepted write, or the cycle after the FIFO empties.

## Configuration
- SAMPLE_WRITER_OVF_EN defined: o_overflow port present, sticky semantics as above.
- SAMPLE_WRITER_OVF_EN undefined: port absent. Dropped samples are discarded silently. All other behaviour is identical.

## Structure
- The shared package holds the state enum type and the sample width constant (8).
- The collector and the writer both import that package.
- One sub-module: sample_fifo, a synchronous show-ahead FIFO (params DEPTH, W=8) with full/empty outputs and a simultaneous push/pop rule.
- Control FSM, address counter and overflow flag stay in sample_writer.

## Test plan
Bench parameters: ADDR_W=4, FIFO_DEPTH=4.
- Reset then start; 5 samples 0x11..0x15, i_ready=1 → writes addr 0..4 with data 0x11..0x15; i_stop → o_done one cycle later; o_count=5.
- i_ready=0 for 10 cycles while 6 samples arrive → first 4 kept, 2 dropped, o_overflow=1. Raise i_ready → exactly 4 writes.
- Full FIFO with i_valid and i_ready=1 in the same cycle → no drop; o_overflow stays 0.
- Continuous samples → 16 writes (addr 0..15), then DONE. No write to addr 0 afterwards; o_count=16.
- Reset asserted mid-DRAIN with 3 entries buffered → next cycle o_we=0, o_busy=0, o_count=0, no o_done.
- i_start pulse while busy, and i_stop while IDLE → no state change.

Source files
------------

// File: rtl/sample_writer_pkg.sv
// sample_writer_pkg: definitions shared by the sample writer and the sample
// collector.
//   SAMPLE_W   : width of one audio/ADC sample (8 bits)
//   wr_state_e : record-side control states (IDLE, RUN, DRAIN, DONE)
package sample_writer_pkg;

  localparam int SAMPLE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } wr_state_e;

endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: synchronous show-ahead FIFO. The head entry is visible on dout
// whenever empty is low; pop consumes it.
// Parameters: DEPTH (power of two, >= 2), W (entry width).
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   flush         : discard all contents (takes priority over push/pop)
//   push, din     : write an entry; ignored when full unless a pop happens
//                   in the same cycle
//   pop           : consume the head entry; ignored when empty
//   dout          : head entry
//   full, empty   : occupancy flags
//   count         : number of stored entries
module sample_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [W-1:0] mem_r [DEPTH];
  logic [AW:0]  wr_ptr_r;
  logic [AW:0]  rd_ptr_r;
  logic         do_push_s;
  logic         do_pop_s;

  // Flags and effective push/pop; a full FIFO accepts a push only when the
  // head leaves in the same cycle.
  always_comb begin
    empty     = (wr_ptr_r == rd_ptr_r);
    full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    count     = wr_ptr_r - rd_ptr_r;
    do_pop_s  = pop && !empty;
    do_push_s = push && (!full || do_pop_s);
    dout      = mem_r[rd_ptr_r[AW-1:0]];
  end

  // Read/write pointers (extra MSB distinguishes full from empty).
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/sample_writer.sv
// sample_writer: buffers 8-bit samples arriving on the sampling strobe and
// writes them sequentially from address 0 into external sample memory.
// Optional feature macro: SAMPLE_WRITER_OVF_EN adds the sticky o_overflow
// output; without it dropped samples are discarded silently.
// Parameters: ADDR_W (memory address width), FIFO_DEPTH (buffer entries).
// Ports:
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_start, i_stop     : one-cycle record control pulses
//   i_valid, i_data     : incoming sample strobe and value
//   o_addr, o_data, o_we: memory write request (held until i_ready)
//   i_ready             : memory accepts the write this cycle
//   o_busy              : recording or draining
//   o_done              : one-cycle pulse when a recording completes
//   o_count             : samples written in the current/last recording
//   o_overflow          : sticky dropped-sample flag (SAMPLE_WRITER_OVF_EN)
module sample_writer
  import sample_writer_pkg::*;
#(
  parameter int ADDR_W     = 20,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic                i_stop,
  input  logic                i_valid,
  input  logic [SAMPLE_W-1:0] i_data,
  output logic [ADDR_W-1:0]   o_addr,
  output logic [SAMPLE_W-1:0] o_data,
  output logic                o_we,
  input  logic                i_ready,
  output logic                o_busy,
  output logic                o_done,
  output logic [ADDR_W:0]     o_count
`ifdef SAMPLE_WRITER_OVF_EN
  ,
  output logic                o_overflow
`endif
);

  localparam int FIFO_CW = $clog2(FIFO_DEPTH) + 1;
  // Count value just before memory becomes full (2**ADDR_W - 1).
  localparam logic [ADDR_W:0]    LAST_CNT = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0]    CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [FIFO_CW-1:0] FIFO_ONE = FIFO_CW'(1);

  wr_state_e             state_r;
  wr_state_e             state_next_s;
  logic [ADDR_W:0]       count_r;

  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic [FIFO_CW-1:0]    fifo_count_s;
  logic [SAMPLE_W-1:0]   fifo_head_s;

  logic                  active_s;
  logic                  we_s;
  logic                  accept_s;
  logic                  mem_full_s;
  logic                  push_req_s;
  logic                  push_s;
  logic                  flush_s;
  logic                  empty_after_s;
  logic                  start_s;

  // Write handshake, push arbitration and buffer lookahead.
  always_comb begin
    start_s    = (state_r == ST_IDLE) && i_start;
    active_s   = (state_r == ST_RUN) || (state_r == ST_DRAIN);
    we_s       = active_s && !fifo_empty_s;
    accept_s   = we_s && i_ready;
    // The accepted write that lands on the last address ends the recording.
    mem_full_s = accept_s && (count_r == LAST_CNT);
    push_req_s = (state_r == ST_RUN) && i_valid;
    push_s     = push_req_s && !mem_full_s && (!fifo_full_s || accept_s);
    // Entering DONE on memory full discards whatever is still buffered.
    flush_s    = start_s || mem_full_s;
    // Buffer will be empty after this edge: lets o_done follow the last
    // write (or the stop on an already empty buffer) by exactly one cycle.
    empty_after_s = !push_s &&
                    (fifo_empty_s || ((fifo_count_s == FIFO_ONE) && accept_s));
  end

  sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (SAMPLE_W)
  ) u_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .flush (flush_s),
    .push  (push_s),
    .pop   (accept_s),
    .din   (i_data),
    .dout  (fifo_head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // Control FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Control FSM next-state logic; memory full overrides stop/drain.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (i_start) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (mem_full_s) begin
          state_next_s = ST_DONE;
        end else if (i_stop) begin
          state_next_s = empty_after_s ? ST_DONE : ST_DRAIN;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (mem_full_s || empty_after_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_DRAIN;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Write address / sample counter; both advance together on each accepted
  // write, so the address is the low bits of the count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_r <= '0;
    end else if (start_s) begin
      count_r <= '0;
    end else if (accept_s) begin
      count_r <= count_r + CNT_ONE;
    end
  end

`ifdef SAMPLE_WRITER_OVF_EN
  logic overflow_r;
  logic drop_s;

  // A sample offered in RUN but not pushed was dropped.
  always_comb begin
    drop_s = push_req_s && !push_s;
  end

  // Sticky overflow flag, cleared only by reset or a new recording.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      overflow_r <= 1'b0;
    end else if (start_s) begin
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
    end
  end

  // Overflow output.
  always_comb begin
    o_overflow = overflow_r;
  end
`endif

  // Control FSM outputs, decoded from registered state and buffer pointers.
  always_comb begin
    o_we    = we_s;
    o_data  = we_s ? fifo_head_s : '0;
    o_addr  = count_r[ADDR_W-1:0];
    o_busy  = active_s;
    o_done  = (state_r == ST_DONE);
    o_count = count_r;
  end

endmodule
